// File: rtl/uart_tx_arbiter_if.sv
// Bus between byte producers, the round-robin UART arbiter and the uart_tx core.
// Groups the request/ack handshake and the uart_tx start/data/busy signals.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshake: requester i raises req_valid[i] with req_data[8*i+:8] stable and
  // keeps both until req_ack[i] pulses for one clk; the byte is captured on that
  // same edge, so the requester may drop or change its request afterwards.
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ack;
  logic [ID_W-1:0]    grant_id;
  logic [7:0]         uart_data;
  logic               uart_start;
  logic               uart_busy;
  logic               arb_busy;
  logic               timeout_err;

  modport master (
    output req_valid, req_data, uart_busy,
    input  req_ack, grant_id, uart_data, uart_start, arb_busy, timeout_err
  );

  modport slave (
    input  req_valid, req_data, uart_busy,
    output req_ack, grant_id, uart_data, uart_start, arb_busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte producers.
// Optional START-phase timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  uart_tx_arbiter_if.slave    bus,
  output logic [1:0]          fsm_state
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]       state;
  logic             busy_meta;
  logic             busy_s;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  pick_id;
  logic             pick_found;
  logic [7:0]       uart_data;
  logic             uart_start;
  logic [N_REQ-1:0] req_ack;
  logic             timeout_hit;
  logic             timeout_err;
  logic [7:0]       req_bytes [N_REQ];

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int step);
    int s;
    s = (int'(base) + step + 1) % N_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_bytes[i] = bus.req_data[8*i +: 8];
    end
  end

  // Search starts just after the previous owner so every pending requester is
  // reached within N_REQ-1 other frames.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_found && bus.req_valid[rr_idx(last_grant, k)]) begin
        pick_found = 1'b1;
        pick_id    = rr_idx(last_grant, k);
      end
    end
  end

  // tx_busy comes from the baud_clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      busy_meta <= bus.uart_busy;
      busy_s    <= busy_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      grant_id   <= '0;
      uart_data  <= 8'h00;
      uart_start <= 1'b0;
      req_ack    <= '0;
    end else begin
      req_ack <= '0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            uart_data  <= req_bytes[pick_id];
            grant_id   <= pick_id;
            req_ack    <= N_REQ'(1) << pick_id;
            uart_start <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          // Seeing busy wins over the timeout on the same clk.
          if (busy_s) begin
            uart_start <= 1'b0;
            state      <= S_WAIT;
          end else if (timeout_hit) begin
            uart_start <= 1'b0;
            last_grant <= grant_id;
            state      <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (!busy_s) begin
            last_grant <= grant_id;
            state      <= S_IDLE;
          end
        end
        default: begin
          uart_start <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] to_cnt;

  // The TIMEOUT_CYC-th START clk is the last one with uart_start high.
  assign timeout_hit = (state == S_START) && !busy_s &&
                       (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (state != S_START) begin
        to_cnt <= '0;
      end else if (!timeout_hit) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign bus.req_ack     = req_ack;
  assign bus.grant_id    = grant_id;
  assign bus.uart_data   = uart_data;
  assign bus.uart_start  = uart_start;
  assign bus.arb_busy    = (state != S_IDLE);
  assign bus.timeout_err = timeout_err;
  assign fsm_state       = state;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: uart_tx behavioural model, auto-releasing requesters,
// frame scoreboard, table of round-robin vectors and hand-written corner sequences.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int FRAME = 12;
  localparam int TO    = 64;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] base;
    int         n;
    logic [7:0] order;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] fsm_state;
  logic [N-1:0] want;
  logic [N-1:0] done;
  logic [N-1:0] hold_mask;
  logic       model_on;
  logic       model_busy;
  logic       stuck_high;
  int         ack_cnt [N];
  int         snap [N];
  int         te_cnt;
  int         te_snap;
  int         n_vec;
  int         n_err;
  logic [9:0] exp_q [$];
  vec_t       vecs [8];

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  assign bus.req_valid = want & ~done;
  assign bus.uart_busy = model_busy | stuck_high;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || fsm_state != 2'd0 || (bus.req_valid & ~hold_mask) != 0)
           && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("idle_reached", (c < budget), 1);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    int c;
    c = 0;
    while (fsm_state != s && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("state_reached", (c < budget), 1);
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < N; i++) bus.req_data[8*i +: 8] = base + 8'(i);
  endtask

  task automatic take_snap();
    for (int i = 0; i < N; i++) snap[i] = ack_cnt[i];
    te_snap = te_cnt;
  endtask

  // Requesters: drop req_valid after their ack unless held; count acks and timeouts.
  initial begin
    done = '0;
    te_cnt = 0;
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && bus.req_ack != '0) begin
        check("ack_onehot", $countones(bus.req_ack), 1);
      end
      for (int i = 0; i < N; i++) begin
        if (!want[i]) done[i] = 1'b0;
        else if (bus.req_ack[i]) begin
          ack_cnt[i]++;
          check("ack_grant_id", bus.grant_id, i);
          if (!hold_mask[i]) done[i] = 1'b1;
        end
      end
      if (bus.timeout_err) te_cnt++;
    end
  end

  // uart_tx model: latches start a couple of clks later, then stays busy for a frame.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (model_on && reset_n && bus.uart_start) begin
        repeat (2) @(posedge clk);
        #1;
        check("start_held", bus.uart_start, 1);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_frame: got %0h expected none", {bus.grant_id, bus.uart_data});
        end else begin
          check("frame", {bus.grant_id, bus.uart_data}, exp_q.pop_front());
        end
        model_busy = 1'b1;
        repeat (FRAME) @(posedge clk);
        #1;
        model_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int c;
    logic [1:0] id;
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    want = '0;
    hold_mask = '0;
    model_on = 1'b1;
    stuck_high = 1'b0;
    bus.req_data = '0;

    vecs[0] = '{4'b1111, 8'h10, 4, 8'b11_10_01_00};
    vecs[1] = '{4'b0001, 8'hA5, 1, 8'b00_00_00_00};
    vecs[2] = '{4'b0101, 8'h20, 2, 8'b00_00_00_10};
    vecs[3] = '{4'b1010, 8'h30, 2, 8'b00_00_11_01};
    vecs[4] = '{4'b0110, 8'h40, 2, 8'b00_00_10_01};
    vecs[5] = '{4'b1001, 8'h50, 2, 8'b00_00_00_11};
    vecs[6] = '{4'b1000, 8'h60, 1, 8'b00_00_00_11};
    vecs[7] = '{4'b1100, 8'h70, 2, 8'b00_00_11_10};

    repeat (3) @(negedge clk);
    check("rst_uart_start", bus.uart_start, 0);
    check("rst_arb_busy", bus.arb_busy, 0);
    check("rst_req_ack", bus.req_ack, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_uart_data", bus.uart_data, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    check("rst_state", fsm_state, 0);

    // Busy stuck high at reset release: nothing may start without a request.
    stuck_high = 1'b1;
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("stuck_state", fsm_state, 0);
    check("stuck_arb_busy", bus.arb_busy, 0);
    check("stuck_uart_start", bus.uart_start, 0);
    stuck_high = 1'b0;
    repeat (4) @(negedge clk);

    foreach (vecs[v]) begin
      take_snap();
      set_data(vecs[v].base);
      for (int k = 0; k < vecs[v].n; k++) begin
        id = vecs[v].order[2*k +: 2];
        exp_q.push_back({id, vecs[v].base + 8'(id)});
      end
      want = vecs[v].mask;
      @(posedge clk);
      #1;
      check("grant_latency_start", bus.uart_start, 1);
      check("first_grant_id", bus.grant_id, vecs[v].order[1:0]);
      check("first_ack", bus.req_ack, 4'b0001 << vecs[v].order[1:0]);
      @(negedge clk);
      wait_idle(3000);
      for (int i = 0; i < N; i++) check("ack_count", ack_cnt[i] - snap[i], vecs[v].mask[i]);
      want = '0;
      repeat (2) @(negedge clk);
    end

    // Fairness: requesters 0 and 2 stay valid; grants must alternate.
    take_snap();
    set_data(8'h80);
    hold_mask = 4'b0101;
    exp_q.push_back({2'd0, 8'h80});
    exp_q.push_back({2'd2, 8'h82});
    exp_q.push_back({2'd0, 8'h80});
    exp_q.push_back({2'd2, 8'h82});
    want = 4'b0101;
    c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("fair_done", (c < 3000), 1);
    want = '0;
    hold_mask = '0;
    wait_idle(3000);
    check("fair_ack0", ack_cnt[0] - snap[0], 2);
    check("fair_ack2", ack_cnt[2] - snap[2], 2);
    repeat (2) @(negedge clk);

    // Late withdrawal: requester 1 shows up during WAIT and leaves before IDLE.
    take_snap();
    set_data(8'h90);
    exp_q.push_back({2'd0, 8'h90});
    want = 4'b0001;
    wait_state(2'd2, 200);
    want = 4'b0011;
    repeat (3) @(negedge clk);
    want = 4'b0001;
    wait_idle(3000);
    repeat (20) @(negedge clk);
    check("late_ack0", ack_cnt[0] - snap[0], 1);
    check("late_ack1", ack_cnt[1] - snap[1], 0);
    check("late_queue_empty", exp_q.size(), 0);
    want = '0;
    repeat (2) @(negedge clk);

    // uart_tx never answers.
    take_snap();
    set_data(8'hA0);
    model_on = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    want = 4'b0110;
    @(posedge clk);
    #1;
    check("to_grant_id", bus.grant_id, 1);
    c = 0;
    @(negedge clk);
    while (bus.uart_start && c < 500) begin
      c++;
      @(negedge clk);
    end
    check("to_start_len", c, TO);
    exp_q.push_back({2'd2, 8'hA2});
    model_on = 1'b1;
    wait_idle(3000);
    check("to_err_pulses", te_cnt - te_snap, 1);
    check("to_ack1", ack_cnt[1] - snap[1], 1);
    check("to_ack2", ack_cnt[2] - snap[2], 1);
`else
    want = 4'b0010;
    repeat (100) @(negedge clk);
    check("hold_state", fsm_state, 1);
    check("hold_start", bus.uart_start, 1);
    check("hold_no_err", te_cnt - te_snap, 0);
    exp_q.push_back({2'd1, 8'hA1});
    model_on = 1'b1;
    wait_idle(3000);
    check("hold_ack1", ack_cnt[1] - snap[1], 1);
`endif
    want = '0;
    repeat (2) @(negedge clk);

    // Reset while WAITing: outputs clear at once, pointer returns to requester 0.
    set_data(8'hB0);
    exp_q.push_back({2'd2, 8'hB2});
    want = 4'b0100;
    wait_state(2'd2, 200);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_start", bus.uart_start, 0);
    check("mid_rst_arb_busy", bus.arb_busy, 0);
    check("mid_rst_ack", bus.req_ack, 0);
    check("mid_rst_state", fsm_state, 0);
    want = '0;
    c = 0;
    while (model_busy && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("model_quiet", (c < 200), 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    take_snap();
    set_data(8'hC0);
    exp_q.push_back({2'd0, 8'hC0});
    exp_q.push_back({2'd1, 8'hC1});
    want = 4'b0011;
    @(posedge clk);
    #1;
    check("post_rst_grant", bus.grant_id, 0);
    @(negedge clk);
    wait_idle(3000);
    check("post_rst_ack0", ack_cnt[0] - snap[0], 1);
    check("post_rst_ack1", ack_cnt[1] - snap[1], 1);
    want = '0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
